dog_extrema: RTL and testbench

- Receiving end of the DoG stream: consumes the three signed difference-of-Gaussian planes produced per pixel in raster order.
- Detects 3x3x3 scale-space extrema centred on the middle plane (dog2) and emits keypoint candidates with coordinates, polarity and value.
- Sits between the DoG generator and keypoint refinement/descriptor logic.

---
 rtl/dog_extrema.sv | 187 ++++++++++++++++++
 tb/tb_dog_extrema.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dog_extrema.sv
// 3x3x3 scale-space extremum detector over three streamed DoG planes.
// Emits one registered result per accepted sample; keys carry centre coordinates, polarity and value.
module dog_extrema #(
    parameter int WIDE   = 230,
    parameter int HIGN   = 235,
    parameter int DW     = 8,
    parameter int CNT_DW = 16,
    parameter int THRESH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DW-1:0]     data_dog1,
    input  logic [DW-1:0]     data_dog2,
    input  logic [DW-1:0]     data_dog3,
    output logic              valid_out,
    output logic              key_flag,
    output logic              key_pol,
    output logic [CNT_DW-1:0] key_x,
    output logic [CNT_DW-1:0] key_y,
    output logic [DW-1:0]     key_val,
    output logic              frame_done,
    output logic [CNT_DW-1:0] key_count
);

    localparam int AW = (WIDE > 1) ? $clog2(WIDE) : 1;
    localparam logic signed [DW-1:0] THR_P = DW'(THRESH);
    localparam logic signed [DW-1:0] THR_N = -THR_P;

    logic [CNT_DW-1:0] x_q, x_d, y_q, y_d;
    logic [CNT_DW-1:0] run_cnt_q, run_cnt_d, run_inc;
    logic [AW-1:0]     addr;

    // lb_a holds row y-1, lb_b holds row y-2, one pair per plane
    logic signed [DW-1:0] lb_a [3][WIDE];
    logic signed [DW-1:0] lb_b [3][WIDE];
    logic signed [DW-1:0] din  [3];
    logic signed [DW-1:0] wnd  [3][3][3];
    logic signed [DW-1:0] win_q [3][3][2];
    logic signed [DW-1:0] win_d [3][3][2];
    logic signed [DW-1:0] ctr;

    logic is_max, is_min, interior, is_key, last_px;

    logic              valid_out_q, valid_out_d;
    logic              key_flag_q, key_flag_d;
    logic              key_pol_q, key_pol_d;
    logic [CNT_DW-1:0] key_x_q, key_x_d;
    logic [CNT_DW-1:0] key_y_q, key_y_d;
    logic [DW-1:0]     key_val_q, key_val_d;
    logic              frame_done_q, frame_done_d;
    logic [CNT_DW-1:0] key_count_q, key_count_d;

    // Assemble the full window: columns 0/1 from registers, column 2 from the live read/input.
    always_comb begin
        din[0] = data_dog1;
        din[1] = data_dog2;
        din[2] = data_dog3;
        addr   = x_q[AW-1:0];
        for (int unsigned p = 0; p < 3; p++) begin
            for (int unsigned r = 0; r < 3; r++) begin
                wnd[p][r][0] = win_q[p][r][0];
                wnd[p][r][1] = win_q[p][r][1];
            end
            wnd[p][0][2] = lb_b[p][addr];
            wnd[p][1][2] = lb_a[p][addr];
            wnd[p][2][2] = din[p];
        end
        for (int unsigned p = 0; p < 3; p++) begin
            for (int unsigned r = 0; r < 3; r++) begin
                win_d[p][r][0] = win_q[p][r][0];
                win_d[p][r][1] = win_q[p][r][1];
                if (valid_in) begin
                    win_d[p][r][0] = wnd[p][r][1];
                    win_d[p][r][1] = wnd[p][r][2];
                end
            end
        end
    end

    always_comb begin
        ctr    = wnd[1][1][1];
        is_max = 1'b1;
        is_min = 1'b1;
        for (int unsigned p = 0; p < 3; p++) begin
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    if (!(p == 1 && r == 1 && c == 1)) begin
                        if (!(ctr > wnd[p][r][c])) is_max = 1'b0;
                        if (!(ctr < wnd[p][r][c])) is_min = 1'b0;
                    end
                end
            end
        end
        interior = (x_q >= CNT_DW'(2)) && (y_q >= CNT_DW'(2));
        is_key   = interior && ((is_max && (ctr >= THR_P)) || (is_min && (ctr <= THR_N)));
        last_px  = (x_q == CNT_DW'(WIDE - 1)) && (y_q == CNT_DW'(HIGN - 1));
    end

    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        run_cnt_d    = run_cnt_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        key_flag_d   = key_flag_q;
        key_pol_d    = key_pol_q;
        key_x_d      = key_x_q;
        key_y_d      = key_y_q;
        key_val_d    = key_val_q;
        key_count_d  = key_count_q;
        run_inc      = (is_key && (run_cnt_q != '1)) ? run_cnt_q + CNT_DW'(1) : run_cnt_q;
        if (valid_in) begin
            valid_out_d = 1'b1;
            key_flag_d  = is_key;
            key_pol_d   = is_key && is_max;
            key_x_d     = is_key ? x_q - CNT_DW'(1) : '0;
            key_y_d     = is_key ? y_q - CNT_DW'(1) : '0;
            key_val_d   = is_key ? ctr : '0;
            if (last_px) begin
                frame_done_d = 1'b1;
                key_count_d  = run_inc;
                run_cnt_d    = '0;
            end else begin
                run_cnt_d = run_inc;
            end
            if (x_q == CNT_DW'(WIDE - 1)) begin
                x_d = '0;
                y_d = (y_q == CNT_DW'(HIGN - 1)) ? '0 : y_q + CNT_DW'(1);
            end else begin
                x_d = x_q + CNT_DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (valid_in) begin
            for (int unsigned p = 0; p < 3; p++) begin
                lb_b[p][addr] <= lb_a[p][addr];
                lb_a[p][addr] <= din[p];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q          <= '0;
            y_q          <= '0;
            run_cnt_q    <= '0;
            valid_out_q  <= 1'b0;
            key_flag_q   <= 1'b0;
            key_pol_q    <= 1'b0;
            key_x_q      <= '0;
            key_y_q      <= '0;
            key_val_q    <= '0;
            frame_done_q <= 1'b0;
            key_count_q  <= '0;
            for (int unsigned p = 0; p < 3; p++)
                for (int unsigned r = 0; r < 3; r++)
                    for (int unsigned c = 0; c < 2; c++)
                        win_q[p][r][c] <= '0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            run_cnt_q    <= run_cnt_d;
            valid_out_q  <= valid_out_d;
            key_flag_q   <= key_flag_d;
            key_pol_q    <= key_pol_d;
            key_x_q      <= key_x_d;
            key_y_q      <= key_y_d;
            key_val_q    <= key_val_d;
            frame_done_q <= frame_done_d;
            key_count_q  <= key_count_d;
            win_q        <= win_d;
        end
    end

    assign valid_out  = valid_out_q;
    assign key_flag   = key_flag_q;
    assign key_pol    = key_pol_q;
    assign key_x      = key_x_q;
    assign key_y      = key_y_q;
    assign key_val    = key_val_q;
    assign frame_done = frame_done_q;
    assign key_count  = key_count_q;

endmodule

// File: tb/tb_dog_extrema.sv
// Scoreboard bench for dog_extrema on a reduced 32x24 frame.
// Stimulus pushes hand-derived expected outputs; a monitor pops them on each valid_out.
module tb_dog_extrema;

    localparam int TW = 32;
    localparam int TH = 24;
    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_in = 1'b0;
    logic [DW-1:0] d1 = '0, d2 = '0, d3 = '0;
    logic          valid_out, key_flag, key_pol, frame_done;
    logic [CW-1:0] key_x, key_y, key_count;
    logic [DW-1:0] key_val;

    dog_extrema #(.WIDE(TW), .HIGN(TH), .DW(DW), .CNT_DW(CW), .THRESH(3)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .data_dog1(d1), .data_dog2(d2), .data_dog3(d3),
        .valid_out(valid_out), .key_flag(key_flag), .key_pol(key_pol),
        .key_x(key_x), .key_y(key_y), .key_val(key_val),
        .frame_done(frame_done), .key_count(key_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          flag;
        logic          pol;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [DW-1:0] val;
        logic          fd;
        logic [CW-1:0] kc;
    } exp_t;

    typedef struct {
        int            cx;
        int            cy;
        bit            pol;
        logic [DW-1:0] val;
    } key_t;

    exp_t          exp_q[$];
    key_t          keys[$];
    exp_t          last_exp = '0;
    exp_t          act;
    exp_t          hold;
    logic [CW-1:0] cur_kc = '0;
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] img1 [TH][TW];
    logic [DW-1:0] img2 [TH][TW];
    logic [DW-1:0] img3 [TH][TW];

    assign act = {key_flag, key_pol, key_x, key_y, key_val, frame_done, key_count};

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (act != '0 || valid_out) begin
                errors++;
                $display("FAIL reset_state: got %h valid_out=%b, expected 0", act, valid_out);
            end
            last_exp = '0;
        end else if (valid_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid_out: got %h, expected no output", act);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL output: got %h expected %h (flag pol x y val fd kc)", act, e);
                end
                last_exp = e;
            end
        end else begin
            hold    = last_exp;
            hold.fd = 1'b0;
            checks++;
            if (act !== hold) begin
                errors++;
                $display("FAIL stall_hold: got %h expected %h", act, hold);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d outputs pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic clear_frame();
        for (int y = 0; y < TH; y++)
            for (int x = 0; x < TW; x++) begin
                img1[y][x] = '0;
                img2[y][x] = '0;
                img3[y][x] = '0;
            end
        keys.delete();
    endtask

    task automatic add_key(input int cx, input int cy, input bit pol, input logic [DW-1:0] val);
        key_t k;
        k.cx = cx; k.cy = cy; k.pol = pol; k.val = val;
        keys.push_back(k);
    endtask

    function automatic exp_t expect_for(input int x, input int y);
        exp_t e;
        e = '0;
        foreach (keys[i]) begin
            if (x == keys[i].cx + 1 && y == keys[i].cy + 1) begin
                e.flag = 1'b1;
                e.pol  = keys[i].pol;
                e.x    = CW'(keys[i].cx);
                e.y    = CW'(keys[i].cy);
                e.val  = keys[i].val;
            end
        end
        return e;
    endfunction

    task automatic run_frame(input logic [CW-1:0] kc_final, input bit gaps, input int stop_idx);
        exp_t e;
        bit   last;
        for (int y = 0; y < TH; y++) begin
            for (int x = 0; x < TW; x++) begin
                if (y * TW + x == stop_idx) return;
                if (gaps && $urandom_range(0, 1) == 1) begin
                    @(negedge clk);
                    valid_in = 1'b0;
                end
                last = (x == TW - 1) && (y == TH - 1);
                e    = expect_for(x, y);
                e.fd = last;
                e.kc = last ? kc_final : cur_kc;
                @(negedge clk);
                valid_in = 1'b1;
                d1 = img1[y][x];
                d2 = img2[y][x];
                d3 = img3[y][x];
                exp_q.push_back(e);
                if (last) cur_kc = kc_final;
            end
        end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        cur_kc = '0;
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;

        // all-zero frame
        clear_frame();
        run_frame(16'd0, 1'b0, -1);

        // single positive impulse -> maximum at (10,8)
        clear_frame();
        img2[8][10] = 8'd20;
        add_key(10, 8, 1'b1, 8'd20);
        run_frame(16'd1, 1'b0, -1);

        // negative impulse -> minimum, value 0xEC
        clear_frame();
        img2[8][10] = 8'hEC;
        add_key(10, 8, 1'b0, 8'hEC);
        run_frame(16'd1, 1'b0, -1);

        // below threshold
        clear_frame();
        img2[8][10] = 8'd2;
        run_frame(16'd0, 1'b0, -1);

        // tie in finer plane
        clear_frame();
        img2[8][10] = 8'd20;
        img1[9][10] = 8'd20;
        run_frame(16'd0, 1'b0, -1);

        // larger neighbour in coarser plane
        clear_frame();
        img2[8][10] = 8'd20;
        img3[7][9]  = 8'd25;
        run_frame(16'd0, 1'b0, -1);

        // border impulses
        clear_frame();
        img2[8][0]  = 8'd20;
        img2[8][31] = 8'd20;
        img2[0][10] = 8'd20;
        img2[23][10] = 8'd20;
        run_frame(16'd0, 1'b0, -1);

        // exactly at threshold, and most-negative value
        clear_frame();
        img2[15][20] = 8'd3;
        img2[5][5]   = 8'h80;
        add_key(5, 5, 1'b0, 8'h80);
        add_key(20, 15, 1'b1, 8'd3);
        run_frame(16'd2, 1'b0, -1);

        // centre impulse with random input gaps
        clear_frame();
        img2[8][10] = 8'd20;
        add_key(10, 8, 1'b1, 8'd20);
        run_frame(16'd1, 1'b1, -1);

        // aborted frame, reset at pixel (20,12)
        clear_frame();
        img2[4][5]   = 8'd20;
        img2[12][20] = 8'd30;
        add_key(5, 4, 1'b1, 8'd20);
        run_frame(16'd0, 1'b0, 12 * TW + 20);
        do_reset();
        repeat (2) @(negedge clk);

        // fresh frame after reset
        clear_frame();
        img2[6][6]   = 8'd20;
        img2[20][26] = 8'd20;
        add_key(6, 6, 1'b1, 8'd20);
        add_key(26, 20, 1'b1, 8'd20);
        run_frame(16'd2, 1'b0, -1);

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected outputs never appeared, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
